gate_unit_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `logic_gates` unit among NREQ requesters. Each requester presents two operand bits and a 3-bit gate opcode with a valid/ready handshake. The arbiter grants one request, drives the shared unit's `a`/`b` inputs from registers, and selects the requested gate output. It returns the registered result with the requester id on a valid/ready response channel. It sits between the requester blocks and the single `logic_gates` instance.

---
 rtl/gate_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/gate_unit_arbiter.sv | 141 ++++++++++++++
 tb/tb_gate_unit_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_arb_pkg.sv
// Shared types for the gate-unit arbiter: opcode and FSM state enums, default requester count.
package gate_arb_pkg;

    localparam int NREQ_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOT_A = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_RSVD  = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant_i and wraps modulo NREQ.
module rr_arbiter
    import gate_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(last_grant_i) + off) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin front end for one shared logic_gates unit; one transaction in flight at a time.
// Optional GATE_ARB_ERR_EN adds rsp_err, flagging the reserved opcode.
module gate_unit_arbiter
    import gate_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_a,
    input  logic [NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0] req_op,
    output logic              gu_a,
    output logic              gu_b,
    input  logic              gu_and,
    input  logic              gu_or,
    input  logic              gu_not_a,
    input  logic              gu_nand,
    input  logic              gu_nor,
    input  logic              gu_xor,
    input  logic              gu_xnor,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_data,
`ifdef GATE_ARB_ERR_EN
    output logic              rsp_err,
`endif
    output logic [IDW-1:0]    rsp_id
);

    function automatic logic gate_select(gate_op_e op, logic [6:0] g);
        logic r;
        case (op)
            OP_AND:   r = g[0];
            OP_OR:    r = g[1];
            OP_NOT_A: r = g[2];
            OP_NAND:  r = g[3];
            OP_NOR:   r = g[4];
            OP_XOR:   r = g[5];
            OP_XNOR:  r = g[6];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    arb_state_e     state_q;
    logic [IDW-1:0] last_grant_q;
    gate_op_e       op_q;
    logic [IDW-1:0] id_q;
    logic           gu_a_q, gu_b_q;
    logic           rsp_valid_q, rsp_data_q;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_data_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [2:0]      op_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_op
        assign op_arr[gi] = req_op[3*gi +: 3];
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx)
    );

    assign req_ready  = (state_q == ST_IDLE) ? gnt : '0;
    assign rsp_data_d = gate_select(op_q, {gu_xnor, gu_xor, gu_nor, gu_nand,
                                           gu_not_a, gu_or, gu_and});

`ifdef GATE_ARB_ERR_EN
    logic rsp_err_q, rsp_err_d;
    assign rsp_err_d = (op_q == OP_RSVD);
    assign rsp_err   = rsp_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            gu_a_q       <= 1'b0;
            gu_b_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 1'b0;
            rsp_id_q     <= '0;
`ifdef GATE_ARB_ERR_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                // Grant: capture the winner's operands onto the shared unit.
                ST_IDLE: begin
                    if (|req_valid) begin
                        gu_a_q       <= req_a[gnt_idx];
                        gu_b_q       <= req_b[gnt_idx];
                        last_grant_q <= gnt_idx;
                        state_q      <= ST_DRIVE;
                    end
                end
                // Shared unit has settled on gu_a/gu_b; register the selected gate.
                ST_DRIVE: begin
                    rsp_data_q  <= rsp_data_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
`ifdef GATE_ARB_ERR_EN
                    rsp_err_q   <= rsp_err_d;
`endif
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Opcode and id are only consumed after a grant, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && |req_valid) begin
            op_q <= gate_op_e'(op_arr[gnt_idx]);
            id_q <= gnt_idx;
        end
    end

    assign gu_a      = gu_a_q;
    assign gu_b      = gu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: transaction-level reference model checked every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_gate_unit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready, req_a, req_b;
    logic [3*NREQ-1:0] req_op;
    logic              gu_a, gu_b;
    logic              gu_and, gu_or, gu_not_a, gu_nand, gu_nor, gu_xor, gu_xnor;
    logic              rsp_valid, rsp_ready, rsp_data;
    logic [IDW-1:0]    rsp_id;
`ifdef GATE_ARB_ERR_EN
    logic              rsp_err;
`endif

    // Stand-in for the external logic_gates instance.
    assign gu_and   = gu_a & gu_b;
    assign gu_or    = gu_a | gu_b;
    assign gu_not_a = ~gu_a;
    assign gu_nand  = ~(gu_a & gu_b);
    assign gu_nor   = ~(gu_a | gu_b);
    assign gu_xor   = gu_a ^ gu_b;
    assign gu_xnor  = ~(gu_a ^ gu_b);

    gate_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .gu_a      (gu_a),
        .gu_b      (gu_b),
        .gu_and    (gu_and),
        .gu_or     (gu_or),
        .gu_not_a  (gu_not_a),
        .gu_nand   (gu_nand),
        .gu_nor    (gu_nor),
        .gu_xor    (gu_xor),
        .gu_xnor   (gu_xnor),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef GATE_ARB_ERR_EN
        .rsp_err   (rsp_err),
`endif
        .rsp_id    (rsp_id)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: state expressed as "in flight, cycles since grant".
    bit          m_known = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_t     = 0;
    int          m_last  = NREQ - 1;
    logic        m_gu_a, m_gu_b, m_data, m_err, m_pdata, m_perr;
    int          m_id, m_pid;
    int          m_wait [NREQ];

    function automatic logic ref_gate(int op, logic a, logic b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return ~a;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int rr_pick(int last, logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_compare();
        int pick;
        logic [NREQ-1:0] exp_ready;
        if (!m_known) return;
        pick      = m_busy ? -1 : rr_pick(m_last, req_valid);
        exp_ready = (pick >= 0) ? NREQ'(1 << pick) : '0;
        chk("m_req_ready", req_ready, exp_ready);
        chk("m_rsp_valid", rsp_valid, (m_busy && m_t >= 2));
        chk("m_rsp_data",  rsp_data, m_data);
        chk("m_rsp_id",    rsp_id, m_id);
        chk("m_gu_a",      gu_a, m_gu_a);
        chk("m_gu_b",      gu_b, m_gu_b);
`ifdef GATE_ARB_ERR_EN
        chk("m_rsp_err",   rsp_err, m_err);
`endif
    endtask

    task automatic model_advance();
        int pick, op;
        if (rst) begin
            m_known = 1'b1; m_busy = 1'b0; m_t = 0; m_last = NREQ - 1;
            m_gu_a = 1'b0; m_gu_b = 1'b0; m_data = 1'b0; m_id = 0; m_err = 1'b0;
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
            return;
        end
        if (!m_known) return;
        if (!m_busy) begin
            pick = rr_pick(m_last, req_valid);
            if (pick >= 0) begin
                chk("m_starvation_bound", (m_wait[pick] < NREQ), 1);
                for (int i = 0; i < NREQ; i++)
                    m_wait[i] = (i != pick && req_valid[i]) ? m_wait[i] + 1 : 0;
                op      = int'(req_op[3*pick +: 3]);
                m_busy  = 1'b1;
                m_t     = 1;
                m_last  = pick;
                m_gu_a  = req_a[pick];
                m_gu_b  = req_b[pick];
                m_pdata = ref_gate(op, req_a[pick], req_b[pick]);
                m_perr  = (op == 7);
                m_pid   = pick;
            end
        end else if (m_t < 2) begin
            m_t++;
            if (m_t == 2) begin
                m_data = m_pdata; m_id = m_pid; m_err = m_perr;
            end
        end else if (rsp_ready) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_compare();
    endtask

    task automatic cyc_end();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_gu_a"},      gu_a, 0);
        chk({tag, "_gu_b"},      gu_b, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"},  rsp_data, 0);
        chk({tag, "_rsp_id"},    rsp_id, 0);
`ifdef GATE_ARB_ERR_EN
        chk({tag, "_rsp_err"},   rsp_err, 0);
`endif
    endtask

    task automatic wait_ready(int id, int maxc);
        logic hit;
        for (int i = 0; i < maxc; i++) begin
            cyc_begin();
            hit = req_ready[id];
            cyc_end();
            if (hit) return;
        end
        chk($sformatf("grant_timeout_req%0d", id), 0, 1);
    endtask

    task automatic wait_rsp(int maxc, output logic d, output int id, output logic e);
        d = 1'b0; id = -1; e = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            cyc_begin();
            if (rsp_valid) begin
                d  = rsp_data;
                id = int'(rsp_id);
`ifdef GATE_ARB_ERR_EN
                e  = rsp_err;
`endif
                cyc_end();
                return;
            end
            cyc_end();
        end
        chk("rsp_timeout", 0, 1);
    endtask

    logic [3:0] tt [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic d, e, d0;
        int   id;
        int   gq[$], gc[$], rq[$];
        logic dq[$];
        logic [NREQ-1:0] acc;

        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b0110; tt[6] = 4'b1001; tt[7] = 4'b0000;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Reset values, then a single XOR from requester 1.
        cyc_begin(); chk_reset_outputs("reset"); cyc_end();
        req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'b0000; req_op[5:3] = 3'd5; rsp_ready = 1'b1;
        cyc_begin(); chk("t1_req_ready", req_ready, 4'b0010); cyc_end();
        req_valid = '0;
        step(1);
        cyc_begin();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_data", rsp_data, 1);
        chk("t1_rsp_id", rsp_id, 1);
        cyc_end();
        step(2);

        // All requesters valid: strict rotation, one grant every 3 cycles.
        do_reset();
        req_valid = 4'b1111; req_a = 4'b1111; req_b = 4'b1111; req_op = '0; rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            cyc_begin();
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin gq.push_back(i); gc.push_back(c); end
            if (rsp_valid && rsp_ready) begin rq.push_back(int'(rsp_id)); dq.push_back(rsp_data); end
            cyc_end();
        end
        req_valid = '0;
        chk("t2_grant_count", gq.size(), 5);
        chk("t2_rsp_count", rq.size(), 5);
        for (int k = 0; k < 5 && k < gq.size() && k < rq.size(); k++) begin
            chk($sformatf("t2_grant%0d_id", k), gq[k], k % 4);
            chk($sformatf("t2_grant%0d_cycle", k), gc[k], 3 * k);
            chk($sformatf("t2_rsp%0d_id", k), rq[k], k % 4);
            chk($sformatf("t2_rsp%0d_data", k), dq[k], 1);
        end
        step(3);

        // Truth-table sweep on requester 2.
        for (int op = 0; op < 7; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                req_op[8:6] = 3'(op);
                req_a[2] = ab[1];
                req_b[2] = ab[0];
                req_valid = 4'b0100;
                wait_ready(2, 8);
                req_valid = '0;
                wait_rsp(8, d, id, e);
                chk($sformatf("t3_op%0d_ab%0d_data", op, ab), d, tt[op][ab]);
                chk($sformatf("t3_op%0d_ab%0d_id", op, ab), id, 2);
            end
        end

        // Response stall with a pending request behind it.
        rsp_ready = 1'b0;
        req_a = 4'b0000; req_b = 4'b0001; req_op[2:0] = 3'd1; req_valid = 4'b0001;
        wait_ready(0, 8);
        req_valid = 4'b1000; req_op[11:9] = 3'd2;
        wait_rsp(8, d0, id, e);
        chk("t4_first_data", d0, 1);
        chk("t4_first_id", id, 0);
        for (int k = 0; k < 5; k++) begin
            cyc_begin();
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_data", rsp_data, d0);
            chk("t4_hold_id", rsp_id, 0);
            chk("t4_hold_ready", req_ready, 0);
            cyc_end();
        end
        rsp_ready = 1'b1;
        step(1);
        cyc_begin(); chk("t4_next_grant", req_ready, 4'b1000); cyc_end();
        req_valid = '0;
        wait_rsp(8, d, id, e);
        chk("t4_second_id", id, 3);

        // Reset while the transaction is in DRIVE.
        req_valid = 4'b0100; req_a[2] = 1'b1; req_b[2] = 1'b1; req_op[8:6] = 3'd0;
        wait_ready(2, 8);
        req_valid = '0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        cyc_begin(); chk_reset_outputs("t5"); cyc_end();
        for (int k = 0; k < 3; k++) begin
            cyc_begin(); chk("t5_no_rsp", rsp_valid, 0); cyc_end();
        end
        req_valid = 4'b1111;
        cyc_begin(); chk("t5_first_grant", req_ready, 4'b0001); cyc_end();
        req_valid = '0;
        wait_rsp(8, d, id, e);

        // Reserved opcode, then XNOR.
        req_valid = 4'b1000; req_a[3] = 1'b1; req_b[3] = 1'b1; req_op[11:9] = 3'd7;
        wait_ready(3, 8);
        req_valid = '0;
        wait_rsp(8, d, id, e);
        chk("t6_rsvd_data", d, 0);
`ifdef GATE_ARB_ERR_EN
        chk("t6_rsvd_err", e, 1);
`endif
        req_valid = 4'b1000; req_a[3] = 1'b0; req_b[3] = 1'b0; req_op[11:9] = 3'd6;
        wait_ready(3, 8);
        req_valid = '0;
        wait_rsp(8, d, id, e);
        chk("t6_xnor_data", d, 1);
`ifdef GATE_ARB_ERR_EN
        chk("t6_xnor_err", e, 0);
`endif

        // Random traffic; requesters hold their request until accepted.
        for (int c = 0; c < 3000; c++) begin
            cyc_begin();
            acc = req_ready;
            cyc_end();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i]    = ($urandom_range(0, 2) == 0);
                    req_a[i]        = 1'($urandom_range(0, 1));
                    req_b[i]        = 1'($urandom_range(0, 1));
                    req_op[3*i +: 3] = 3'($urandom_range(0, 7));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
